bgraph_decoder: RTL and testbench
=================================

# bgraph_decoder

Reads an 8-bit bar-graph (thermometer-code) level display and recovers the thermostat setting behind it: one-hot mode (low fan, high fan, low cool, high cool) plus the turbo flag. This is the inverse of the thermostat-to-bar-graph encoder. It sits on the monitoring side, where a bar graph sampled from the panel is checked against the commanded setting. A sample-strobed stability filter suppresses transient codes, and non-thermometer codes are flagged rather than decoded.

## Interface
- STABLE_CNT, 4: consecutive identical strobed samples required before a code is acted on; legal range 1..15.

- Clk_in  input  1  clock; all state changes on the rising edge.
- Rst_in  input  1  asynchronous, active-high reset.
- Sample_in  input  1  sample strobe; BGraph_in is examined only in cycles where Sample_in=1.
- BGraph_in  input  8  bar-graph code under observation.
- Err_clr_in  input  1  synchronous clear of Err_out.
- Thermo_out  output  4  decoded one-hot mode: [0] low fan, [1] high fan, [2] low cool, [3] high cool; 0000 = off.
- Turbo_out  output  1  decoded turbo flag.
- Valid_out  output  1  one-cycle pulse when Thermo_out/Turbo_out take a new value.
- Err_out  output  1  sticky flag, set when a stable non-thermometer code is seen.

## Operation
- Registers: candidate code CAND[7:0], match counter CNT[3:0] (saturates at STABLE_CNT), committed code COMM[7:0].
- Per strobed sample:
  - If BGraph_in == CAND, then CNT = min(CNT+1, STABLE_CNT).
  - Otherwise CAND = BGraph_in and CNT = 1.
- Stability event: fires on the strobed sample where CNT moves from below STABLE_CNT to STABLE_CNT. This includes a reload to 1 when STABLE_CNT=1. A sample at an already-saturated CNT fires nothing.
- On a stability event with code C:
  - C is a valid code and C != COMM: update COMM, Thermo_out and Turbo_out, and pulse Valid_out.
  - C is a valid code and C == COMM: no output change and no pulse.
  - C is not a valid thermometer code: set Err_out. COMM and the decoded outputs hold, and Valid_out does not pulse.
- Valid codes map to {Thermo_out, Turbo_out} as follows:
  - 00: 0000,0
  - 01: 0001,0
  - 03: 0001,1
  - 07: 0010,0
  - 0F: 0010,1
  - 1F: 0100,0
  - 3F: 0100,1
  - 7F: 1000,0
  - FF: 1000,1
- All other codes are invalid, e.g. 02, 05, 0E, 80, AA.
- Err_out stays set until a cycle with Err_clr_in=1. If a set and a clear land in the same cycle, the set wins.
- Cycles with Sample_in=0 leave CAND, CNT and COMM untouched and produce no events.

## Timing
- Reset values:
  - Thermo_out=0000, Turbo_out=0, Valid_out=0, Err_out=0.
  - CAND=00, CNT=0, COMM=00 (off).
- Reset mid-operation: all of the above apply immediately. Any partial filter count is discarded.
- All outputs are registered.
- Latency: the decoded outputs and Valid_out change on the same rising edge that captures the STABLE_CNT-th consecutive matching sample. Valid_out is high for exactly that one following cycle.
- Err_out rises on the same edge as an invalid stability event. Err_out falls on the edge that captures Err_clr_in=1, unless a set also occurs on that edge.
- Minimum commit interval is STABLE_CNT strobes. With Sample_in held at 1, that is STABLE_CNT cycles after a change of BGraph_in.
- Gaps in Sample_in do not break a run; only a differing strobed sample does.
- After reset, a stable 00 produces no Valid_out pulse because it equals COMM.

## Test plan
- Reset, then Sample_in=1 with BGraph_in=0F held. Required: Valid_out pulses once, on the edge of the 4th sample. Thermo_out=0010, Turbo_out=1. No further pulses while 0F is held.
- Glitch rejection: stable 07 committed, then strobed sequence 1F,1F,07,1F,1F,1F,1F. Required: no change until the 4th consecutive 1F, then Thermo_out=0100, Turbo_out=0, with a single Valid_out pulse.
- Invalid code: 05 held for 4 strobes. Required: Err_out=1 from the 4th edge onward, outputs unchanged, no Valid_out. A subsequent Err_clr_in pulse clears it. A clear coincident with another invalid event leaves Err_out=1.
- Strobe gaps: STABLE_CNT=4, BGraph_in=FF strobed every 3rd cycle. Required: commit on the 4th strobe (edge 10 from the first strobe), giving 1000,1.
- STABLE_CNT=1: sequence 01,03,03,00. Required: Valid_out pulses on the 1st, 2nd and 4th samples with outputs 0001,0 / 0001,1 / 0000,0.
- Reset asserted after 3 matching strobes of 3F. Required: all outputs 0 immediately. After release, 4 fresh strobes of 3F are needed to commit 0100,1.

Source files
------------

// File: rtl/bgraph_decoder.sv
// Bar-graph (thermometer code) to thermostat setting decoder with a strobed
// stability filter; stable non-thermometer codes raise a sticky error flag.
module bgraph_decoder #(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample,
  input  logic [7:0] bgraph,
  input  logic       err_clr,
  output logic [3:0] thermo,
  output logic       turbo,
  output logic       valid,
  output logic       err
);

  localparam logic [3:0] STABLE = 4'(STABLE_CNT);

  logic [7:0] cand;
  logic [3:0] cnt;
  logic [7:0] comm;

  logic       match;
  logic [3:0] cnt_nxt;
  logic       stable_evt;
  logic       code_ok;
  logic [3:0] thermo_d;
  logic       turbo_d;

  // A reload to 1 counts as reaching STABLE, which matters when STABLE is 1.
  always_comb begin
    match      = (bgraph == cand);
    cnt_nxt    = 4'd1;
    if (match)
      cnt_nxt = (cnt == STABLE) ? cnt : cnt + 4'd1;
    stable_evt = sample && (!match || (cnt != STABLE)) && (cnt_nxt == STABLE);
  end

  always_comb begin
    code_ok  = 1'b1;
    thermo_d = 4'b0000;
    turbo_d  = 1'b0;
    case (bgraph)
      8'h00: begin thermo_d = 4'b0000; turbo_d = 1'b0; end
      8'h01: begin thermo_d = 4'b0001; turbo_d = 1'b0; end
      8'h03: begin thermo_d = 4'b0001; turbo_d = 1'b1; end
      8'h07: begin thermo_d = 4'b0010; turbo_d = 1'b0; end
      8'h0F: begin thermo_d = 4'b0010; turbo_d = 1'b1; end
      8'h1F: begin thermo_d = 4'b0100; turbo_d = 1'b0; end
      8'h3F: begin thermo_d = 4'b0100; turbo_d = 1'b1; end
      8'h7F: begin thermo_d = 4'b1000; turbo_d = 1'b0; end
      8'hFF: begin thermo_d = 4'b1000; turbo_d = 1'b1; end
      default: code_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand   <= 8'h00;
      cnt    <= 4'd0;
      comm   <= 8'h00;
      thermo <= 4'b0000;
      turbo  <= 1'b0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (err_clr)
        err <= 1'b0;
      if (sample) begin
        cand <= bgraph;
        cnt  <= cnt_nxt;
        // An error set is written after the clear so it wins on a shared edge.
        if (stable_evt) begin
          if (!code_ok) begin
            err <= 1'b1;
          end else if (bgraph != comm) begin
            comm   <= bgraph;
            thermo <= thermo_d;
            turbo  <= turbo_d;
            valid  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bgraph_decoder.sv
// Table-driven bench for bgraph_decoder: STABLE_CNT=4 and STABLE_CNT=1 instances,
// expected {thermo,turbo,valid,err} queued at drive time and popped after the edge.
module tb_bgraph_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s0, c0, s1, c1;
  logic [7:0] b0, b1;
  logic [3:0] th0, th1;
  logic       tu0, v0, e0, tu1, v1, e1;

  bgraph_decoder #(.STABLE_CNT(4)) dut4 (
    .clk(clk), .rst(rst), .sample(s0), .bgraph(b0), .err_clr(c0),
    .thermo(th0), .turbo(tu0), .valid(v0), .err(e0)
  );

  bgraph_decoder #(.STABLE_CNT(1)) dut1 (
    .clk(clk), .rst(rst), .sample(s1), .bgraph(b1), .err_clr(c1),
    .thermo(th1), .turbo(tu1), .valid(v1), .err(e1)
  );

  typedef struct {
    bit         sel;
    bit         s;
    logic [7:0] b;
    bit         c;
    logic [6:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [6:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic add(bit sel, bit s, logic [7:0] b, bit c,
                     logic [3:0] th, bit tu, bit v, bit e);
    tbl.push_back('{sel, s, b, c, {th, tu, v, e}});
  endtask

  task automatic check(string name, logic [6:0] act);
    logic [6:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got %b, scoreboard empty", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got thermo/turbo/valid/err=%b required %b", name, act, e);
      end
    end
  endtask

  task automatic apply(vec_t t, int idx);
    @(negedge clk);
    s0 = 1'b0; c0 = 1'b0; s1 = 1'b0; c1 = 1'b0;
    if (t.sel) begin
      s1 = t.s; b1 = t.b; c1 = t.c;
    end else begin
      s0 = t.s; b0 = t.b; c0 = t.c;
    end
    exp_q.push_back(t.exp);
    @(posedge clk);
    #1;
    check($sformatf("vec%0d(dut%0d b=%h)", idx, t.sel ? 1 : 4, t.b),
          t.sel ? {th1, tu1, v1, e1} : {th0, tu0, v0, e0});
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], i);
    tbl.delete();
  endtask

  initial begin
    rst = 1'b1;
    s0 = 1'b0; c0 = 1'b0; b0 = 8'h00;
    s1 = 1'b0; c1 = 1'b0; b1 = 8'h00;
    #2;
    exp_q.push_back(7'b0);
    check("reset_dut4", {th0, tu0, v0, e0});
    exp_q.push_back(7'b0);
    check("reset_dut1", {th1, tu1, v1, e1});
    @(negedge clk);
    rst = 1'b0;

    // 0F held: commit on 4th strobe, no further pulses
    for (int i = 0; i < 3; i++) add(0, 1, 8'h0F, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 8'h0F, 0, 4'b0010, 1, 1, 0);
    for (int i = 0; i < 2; i++) add(0, 1, 8'h0F, 0, 4'b0010, 1, 0, 0);
    // 07 commit, then glitch-rejected 1F
    for (int i = 0; i < 3; i++) add(0, 1, 8'h07, 0, 4'b0010, 1, 0, 0);
    add(0, 1, 8'h07, 0, 4'b0010, 0, 1, 0);
    add(0, 1, 8'h1F, 0, 4'b0010, 0, 0, 0);
    add(0, 1, 8'h1F, 0, 4'b0010, 0, 0, 0);
    add(0, 1, 8'h07, 0, 4'b0010, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 8'h1F, 0, 4'b0010, 0, 0, 0);
    add(0, 1, 8'h1F, 0, 4'b0100, 0, 1, 0);
    add(0, 1, 8'h1F, 0, 4'b0100, 0, 0, 0);
    // invalid 05: sticky error, clear, saturated run gives no new event
    for (int i = 0; i < 3; i++) add(0, 1, 8'h05, 0, 4'b0100, 0, 0, 0);
    add(0, 1, 8'h05, 0, 4'b0100, 0, 0, 1);
    add(0, 0, 8'h05, 0, 4'b0100, 0, 0, 1);
    add(0, 0, 8'h05, 1, 4'b0100, 0, 0, 0);
    add(0, 1, 8'h05, 0, 4'b0100, 0, 0, 0);
    // clear coincident with a new invalid event: set wins
    for (int i = 0; i < 3; i++) add(0, 1, 8'hAA, 0, 4'b0100, 0, 0, 0);
    add(0, 1, 8'hAA, 1, 4'b0100, 0, 0, 1);
    add(0, 0, 8'h00, 1, 4'b0100, 0, 0, 0);
    // stable code equal to committed code: no pulse
    for (int i = 0; i < 4; i++) add(0, 1, 8'h1F, 0, 4'b0100, 0, 0, 0);
    // FF strobed every 3rd cycle, other cycles carry ignored 00
    for (int k = 0; k < 3; k++) begin
      add(0, 1, 8'hFF, 0, 4'b0100, 0, 0, 0);
      add(0, 0, 8'h00, 0, 4'b0100, 0, 0, 0);
      add(0, 0, 8'h00, 0, 4'b0100, 0, 0, 0);
    end
    add(0, 1, 8'hFF, 0, 4'b1000, 1, 1, 0);
    add(0, 0, 8'h00, 0, 4'b1000, 1, 0, 0);
    // STABLE_CNT=1: 00 after reset is silent, then 01,03,03,00, then invalid 02
    add(1, 1, 8'h00, 0, 4'b0000, 0, 0, 0);
    add(1, 1, 8'h01, 0, 4'b0001, 0, 1, 0);
    add(1, 1, 8'h03, 0, 4'b0001, 1, 1, 0);
    add(1, 1, 8'h03, 0, 4'b0001, 1, 0, 0);
    add(1, 1, 8'h00, 0, 4'b0000, 0, 1, 0);
    add(1, 1, 8'h02, 0, 4'b0000, 0, 0, 1);
    // three matching 3F strobes before the mid-run reset
    for (int i = 0; i < 3; i++) add(0, 1, 8'h3F, 0, 4'b1000, 1, 0, 0);
    run_table();

    @(negedge clk);
    s0 = 1'b0;
    rst = 1'b1;
    #1;
    exp_q.push_back(7'b0);
    check("midrun_reset_dut4", {th0, tu0, v0, e0});
    exp_q.push_back(7'b0);
    check("midrun_reset_dut1", {th1, tu1, v1, e1});
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) add(0, 1, 8'h3F, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 8'h3F, 0, 4'b0100, 1, 1, 0);
    add(0, 1, 8'h3F, 0, 4'b0100, 1, 0, 0);
    run_table();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
